lsb_queue: RTL and testbench

- Parametrised in-order load/store buffer for the out-of-order RISC-V core. Sits between dispatch, the ROB and the memory controller.
- Holds LSB_DEPTH entries in a circular queue and captures operands from NUM_CDB result buses.
- Issues one memory access at a time from the head: stores only after ROB commit, ordinary loads speculatively, IO-region loads only at ROB head.
- On rollback, discards all uncommitted entries while keeping committed stores; an in-flight speculative load is squashed cleanly.

---
 rtl/lsb_queue_if.sv | 71 +++++++
 rtl/lsb_queue.sv | 269 ++++++++++++++++++++++++++
 tb/tb_lsb_queue.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsb_queue_if.sv
// Signal bundle between the load/store buffer and its environment:
// dispatch issue port, CDB broadcast, ROB commit/head, memory port and load result.
interface lsb_queue_if #(
    parameter int unsigned ROB_W   = 4,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_CDB = 2
);
    logic                       rdy;
    logic                       rollback;
    logic                       full;

    logic                       issue_en;
    logic [ROB_W-1:0]           issue_rob;
    logic                       issue_ls;
    logic [2:0]                 issue_funct3;
    logic                       issue_rs1_rdy;
    logic                       issue_rs2_rdy;
    logic [XLEN-1:0]            issue_rs1_val;
    logic [XLEN-1:0]            issue_rs2_val;
    logic [ROB_W-1:0]           issue_rs1_tag;
    logic [ROB_W-1:0]           issue_rs2_tag;
    logic [XLEN-1:0]            issue_imm;

    logic [NUM_CDB-1:0]         cdb_valid;
    logic [NUM_CDB*ROB_W-1:0]   cdb_tag;
    logic [NUM_CDB*XLEN-1:0]    cdb_val;

    logic                       commit_valid;
    logic [ROB_W-1:0]           commit_rob;
    logic [ROB_W-1:0]           rob_head;

    logic                       mem_en;
    logic                       mem_wr;
    logic [XLEN-1:0]            mem_a;
    logic [2:0]                 mem_l;
    logic [XLEN-1:0]            mem_w;
    logic                       mem_done;
    logic [XLEN-1:0]            mem_r;

    logic                       res_valid;
    logic [XLEN-1:0]            res;
    logic [ROB_W-1:0]           res_rob;

    // Buffer side
    modport slave (
        input  rdy, rollback,
        input  issue_en, issue_rob, issue_ls, issue_funct3,
        input  issue_rs1_rdy, issue_rs2_rdy, issue_rs1_val, issue_rs2_val,
        input  issue_rs1_tag, issue_rs2_tag, issue_imm,
        input  cdb_valid, cdb_tag, cdb_val,
        input  commit_valid, commit_rob, rob_head,
        input  mem_done, mem_r,
        output full,
        output mem_en, mem_wr, mem_a, mem_l, mem_w,
        output res_valid, res, res_rob
    );

    // Environment side (dispatch, ROB, CDB, memory controller)
    modport master (
        output rdy, rollback,
        output issue_en, issue_rob, issue_ls, issue_funct3,
        output issue_rs1_rdy, issue_rs2_rdy, issue_rs1_val, issue_rs2_val,
        output issue_rs1_tag, issue_rs2_tag, issue_imm,
        output cdb_valid, cdb_tag, cdb_val,
        output commit_valid, commit_rob, rob_head,
        output mem_done, mem_r,
        input  full,
        input  mem_en, mem_wr, mem_a, mem_l, mem_w,
        input  res_valid, res, res_rob
    );
endinterface

// File: rtl/lsb_queue.sv
// In-order load/store buffer: circular queue of LSB_DEPTH entries, CDB operand
// capture, one memory access at a time from the head, rollback of uncommitted work.
module lsb_queue #(
    parameter int unsigned LSB_DEPTH = 16,
    parameter int unsigned ROB_W     = 4,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_CDB   = 2,
    parameter logic [1:0]  IO_HI     = 2'b11
) (
    input logic        clk,
    input logic        rst,
    lsb_queue_if.slave bus
);
    localparam int unsigned PW = (LSB_DEPTH > 1) ? $clog2(LSB_DEPTH) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    // Queue storage
    logic [LSB_DEPTH-1:0] ent_valid;
    logic [LSB_DEPTH-1:0] ent_commit;
    logic [LSB_DEPTH-1:0] ent_ls;
    logic [LSB_DEPTH-1:0] ent_rs1_rdy;
    logic [LSB_DEPTH-1:0] ent_rs2_rdy;
    logic [2:0]           ent_funct3  [LSB_DEPTH];
    logic [ROB_W-1:0]     ent_rob     [LSB_DEPTH];
    logic [ROB_W-1:0]     ent_rs1_tag [LSB_DEPTH];
    logic [ROB_W-1:0]     ent_rs2_tag [LSB_DEPTH];
    logic [XLEN-1:0]      ent_rs1_val [LSB_DEPTH];
    logic [XLEN-1:0]      ent_rs2_val [LSB_DEPTH];
    logic [XLEN-1:0]      ent_imm     [LSB_DEPTH];

    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [PW:0]          count;
    logic                 squash;

    state_t               state;
    state_t               state_n;

    // Registered memory/result outputs plus the in-flight access context
    logic                 mem_en_q;
    logic                 mem_wr_q;
    logic [XLEN-1:0]      mem_a_q;
    logic [2:0]           mem_l_q;
    logic [XLEN-1:0]      mem_w_q;
    logic                 res_valid_q;
    logic [XLEN-1:0]      res_q;
    logic [ROB_W-1:0]     res_rob_q;
    logic [2:0]           cur_funct3;
    logic [ROB_W-1:0]     cur_rob;

    // Combinational helpers
    logic                 full;
    logic                 enq;
    logic [XLEN-1:0]      h_addr;
    logic                 eligible;
    logic [2:0]           h_len;
    logic [PW:0]          ccount;
    logic [XLEN:0]        cap1 [LSB_DEPTH];
    logic [XLEN:0]        cap2 [LSB_DEPTH];
    logic [XLEN:0]        byp1;
    logic [XLEN:0]        byp2;
    logic                 launch;
    logic                 pop;
    logic                 pop_live;
    logic                 res_fire;
    logic [XLEN-1:0]      ext;

    assign full          = (count == (PW+1)'(LSB_DEPTH));
    assign enq           = bus.issue_en && !full;
    assign bus.full      = full;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_a     = mem_a_q;
    assign bus.mem_l     = mem_l_q;
    assign bus.mem_w     = mem_w_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res       = res_q;
    assign bus.res_rob   = res_rob_q;

    // Returns {hit, value} for the lowest-index valid CDB channel carrying tag
    function automatic logic [XLEN:0] cdb_match(
        input logic [ROB_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       v,
        input logic [NUM_CDB*ROB_W-1:0] t,
        input logic [NUM_CDB*XLEN-1:0]  d
    );
        logic [XLEN:0] r;
        r = '0;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            if (!r[XLEN] && v[k] && t[k*ROB_W +: ROB_W] == tag) begin
                r = {1'b1, d[k*XLEN +: XLEN]};
            end
        end
        return r;
    endfunction

    // CDB lookups for every queued operand and for the operands being issued
    always_comb begin
        for (int unsigned i = 0; i < LSB_DEPTH; i++) begin
            cap1[i] = cdb_match(ent_rs1_tag[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
            cap2[i] = cdb_match(ent_rs2_tag[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
        end
        byp1 = cdb_match(bus.issue_rs1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
        byp2 = cdb_match(bus.issue_rs2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
    end

    // Head entry address, access size and issue eligibility
    always_comb begin
        h_addr   = ent_rs1_val[head] + ent_imm[head];
        eligible = ent_valid[head] && ent_rs1_rdy[head] && ent_rs2_rdy[head] &&
                   ((ent_ls[head] && ent_commit[head]) ||
                    (!ent_ls[head] && ((h_addr[17:16] != IO_HI) ||
                                       (ent_rob[head] == bus.rob_head))));
        case (ent_funct3[head][1:0])
            2'b00:   h_len = 3'd1;
            2'b01:   h_len = 3'd2;
            default: h_len = 3'd4;
        endcase
    end

    // Number of committed entries; they always form a run starting at head
    always_comb begin
        ccount = '0;
        for (int unsigned i = 0; i < LSB_DEPTH; i++) begin
            ccount = ccount + (PW+1)'(ent_valid[i] & ent_commit[i]);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (bus.rdy) begin
            state <= state_n;
        end
    end

    // FSM next state; a speculative head is not launched in a rollback cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (eligible && (!bus.rollback || ent_ls[head])) state_n = BUSY;
            BUSY: if (bus.mem_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM outputs: launch/pop strobes and whether the pop retires a live entry
    always_comb begin
        launch   = (state == IDLE) && (state_n == BUSY);
        pop      = (state == BUSY) && bus.mem_done;
        // A squashed load was already removed from the queue by the rollback,
        // so its completion must not advance head or decrement count.
        pop_live = pop && !(squash || (bus.rollback && !mem_wr_q));
        res_fire = pop && !mem_wr_q && !squash && !bus.rollback;
    end

    // Load data extension according to the in-flight funct3
    always_comb begin
        case (cur_funct3)
            3'b000:  ext = {{(XLEN-8){bus.mem_r[7]}}, bus.mem_r[7:0]};
            3'b001:  ext = {{(XLEN-16){bus.mem_r[15]}}, bus.mem_r[15:0]};
            3'b100:  ext = {{(XLEN-8){1'b0}}, bus.mem_r[7:0]};
            3'b101:  ext = {{(XLEN-16){1'b0}}, bus.mem_r[15:0]};
            default: ext = bus.mem_r;
        endcase
    end

    // Queue state: enqueue, CDB capture, commit marking, pop and rollback
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            ent_valid  <= '0;
            ent_commit <= '0;
            squash     <= 1'b0;
        end else if (bus.rdy) begin
            if (bus.rollback) begin
                for (int unsigned i = 0; i < LSB_DEPTH; i++) begin
                    if (!ent_commit[i]) ent_valid[i] <= 1'b0;
                end
                tail <= head + ccount[PW-1:0];
                if (pop_live) begin
                    ent_valid[head]  <= 1'b0;
                    ent_commit[head] <= 1'b0;
                    head             <= head + PW'(1);
                    count            <= ccount - (PW+1)'(1);
                end else begin
                    count <= ccount;
                end
                if ((state == BUSY) && !mem_wr_q && !bus.mem_done) squash <= 1'b1;
                else if (pop) squash <= 1'b0;
            end else begin
                for (int unsigned i = 0; i < LSB_DEPTH; i++) begin
                    if (ent_valid[i] && !ent_rs1_rdy[i] && cap1[i][XLEN]) begin
                        ent_rs1_rdy[i] <= 1'b1;
                        ent_rs1_val[i] <= cap1[i][XLEN-1:0];
                    end
                    if (ent_valid[i] && !ent_rs2_rdy[i] && cap2[i][XLEN]) begin
                        ent_rs2_rdy[i] <= 1'b1;
                        ent_rs2_val[i] <= cap2[i][XLEN-1:0];
                    end
                    if (bus.commit_valid && ent_valid[i] && ent_ls[i] &&
                        ent_rob[i] == bus.commit_rob) begin
                        ent_commit[i] <= 1'b1;
                    end
                end
                if (pop_live) begin
                    ent_valid[head]  <= 1'b0;
                    ent_commit[head] <= 1'b0;
                    head             <= head + PW'(1);
                end
                if (enq) begin
                    ent_valid[tail]   <= 1'b1;
                    ent_commit[tail]  <= 1'b0;
                    ent_ls[tail]      <= bus.issue_ls;
                    ent_funct3[tail]  <= bus.issue_funct3;
                    ent_rob[tail]     <= bus.issue_rob;
                    ent_imm[tail]     <= bus.issue_imm;
                    ent_rs1_tag[tail] <= bus.issue_rs1_tag;
                    ent_rs2_tag[tail] <= bus.issue_rs2_tag;
                    ent_rs1_rdy[tail] <= bus.issue_rs1_rdy || byp1[XLEN];
                    ent_rs2_rdy[tail] <= bus.issue_rs2_rdy || byp2[XLEN];
                    ent_rs1_val[tail] <= bus.issue_rs1_rdy ? bus.issue_rs1_val : byp1[XLEN-1:0];
                    ent_rs2_val[tail] <= bus.issue_rs2_rdy ? bus.issue_rs2_val : byp2[XLEN-1:0];
                    tail              <= tail + PW'(1);
                end
                count <= count + (PW+1)'(enq) - (PW+1)'(pop_live);
                if (pop) squash <= 1'b0;
            end
        end
    end

    // Memory request and load result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_a_q     <= '0;
            mem_l_q     <= '0;
            mem_w_q     <= '0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
            res_rob_q   <= '0;
            cur_funct3  <= '0;
            cur_rob     <= '0;
        end else if (bus.rdy) begin
            res_valid_q <= 1'b0;
            if (launch) begin
                mem_en_q   <= 1'b1;
                mem_wr_q   <= ent_ls[head];
                mem_a_q    <= h_addr;
                mem_l_q    <= h_len;
                mem_w_q    <= ent_rs2_val[head];
                cur_funct3 <= ent_funct3[head];
                cur_rob    <= ent_rob[head];
            end else if (pop) begin
                mem_en_q <= 1'b0;
                if (res_fire) begin
                    res_valid_q <= 1'b1;
                    res_q       <= ext;
                    res_rob_q   <= cur_rob;
                end
            end
        end
    end
endmodule

// File: tb/tb_lsb_queue.sv
// Directed self-checking bench for lsb_queue.
module tb_lsb_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lsb_queue_if #(.ROB_W(4), .XLEN(32), .NUM_CDB(2)) bus ();

    lsb_queue #(
        .LSB_DEPTH(16), .ROB_W(4), .XLEN(32), .NUM_CDB(2), .IO_HI(2'b11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_issue(input logic [3:0] rob, input logic ls, input logic [2:0] f3,
                            input logic r1rdy, input logic [31:0] r1val, input logic [3:0] r1tag,
                            input logic [31:0] r2val, input logic [31:0] imm);
        bus.issue_en      = 1'b1;
        bus.issue_rob     = rob;
        bus.issue_ls      = ls;
        bus.issue_funct3  = f3;
        bus.issue_rs1_rdy = r1rdy;
        bus.issue_rs1_val = r1val;
        bus.issue_rs1_tag = r1tag;
        bus.issue_rs2_rdy = 1'b1;
        bus.issue_rs2_val = r2val;
        bus.issue_rs2_tag = 4'd0;
        bus.issue_imm     = imm;
        step();
        bus.issue_en      = 1'b0;
    endtask

    task automatic complete(input logic [31:0] r);
        bus.mem_done = 1'b1;
        bus.mem_r    = r;
        step();
        bus.mem_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got=%0h exp=0", bus.mem_en); end
        checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got=%0h exp=0", bus.mem_wr); end
        checks++; if (bus.mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got=%0h exp=0", bus.mem_a); end
        checks++; if (bus.mem_l !== 3'd0) begin errors++; $display("FAIL reset_mem_l got=%0h exp=0", bus.mem_l); end
        checks++; if (bus.mem_w !== 32'h0) begin errors++; $display("FAIL reset_mem_w got=%0h exp=0", bus.mem_w); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%0h exp=0", bus.res_valid); end
        checks++; if (bus.res !== 32'h0) begin errors++; $display("FAIL reset_res got=%0h exp=0", bus.res); end
        checks++; if (bus.res_rob !== 4'd0) begin errors++; $display("FAIL reset_res_rob got=%0h exp=0", bus.res_rob); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0h exp=0", bus.full); end
    endtask

    task automatic test_lw();
        do_issue(4'd0, 1'b0, 3'b010, 1'b1, 32'h100, 4'd0, 32'h0, 32'h4);
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL lw_no_early_issue got=%0h exp=0", bus.mem_en); end
        step();
        checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL lw_mem_en got=%0h exp=1", bus.mem_en); end
        checks++; if (bus.mem_a !== 32'h104) begin errors++; $display("FAIL lw_mem_a got=%0h exp=104", bus.mem_a); end
        checks++; if (bus.mem_l !== 3'd4) begin errors++; $display("FAIL lw_mem_l got=%0h exp=4", bus.mem_l); end
        checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL lw_mem_wr got=%0h exp=0", bus.mem_wr); end
        complete(32'hDEADBEEF);
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL lw_res_valid got=%0h exp=1", bus.res_valid); end
        checks++; if (bus.res !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_res got=%0h exp=deadbeef", bus.res); end
        checks++; if (bus.res_rob !== 4'd0) begin errors++; $display("FAIL lw_res_rob got=%0h exp=0", bus.res_rob); end
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL lw_mem_en_drop got=%0h exp=0", bus.mem_en); end
        step();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL lw_res_pulse got=%0h exp=0", bus.res_valid); end
    endtask

    task automatic test_extension();
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] rd  [4] = '{32'h80, 32'h80, 32'h8001, 32'h8001};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
        logic [2:0]  len [4] = '{3'd1, 3'd1, 3'd2, 3'd2};
        for (int i = 0; i < 4; i++) begin
            do_issue(4'(i + 1), 1'b0, f3[i], 1'b1, 32'h1000, 4'd0, 32'h0, 32'(i * 4));
            step();
            checks++; if (bus.mem_l !== len[i]) begin errors++; $display("FAIL ext_mem_l[%0d] got=%0h exp=%0h", i, bus.mem_l, len[i]); end
            complete(rd[i]);
            checks++; if (bus.res !== exp[i] || bus.res_valid !== 1'b1) begin
                errors++; $display("FAIL ext_res[%0d] got=%0h valid=%0h exp=%0h valid=1", i, bus.res, bus.res_valid, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_store();
        do_issue(4'd3, 1'b1, 3'b010, 1'b1, 32'h200, 4'd0, 32'h12345678, 32'h8);
        step();
        step();
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL st_wait_commit got=%0h exp=0", bus.mem_en); end
        bus.commit_valid = 1'b1;
        bus.commit_rob   = 4'd3;
        step();
        bus.commit_valid = 1'b0;
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL st_commit_latency got=%0h exp=0", bus.mem_en); end
        step();
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_wr !== 1'b1) begin
            errors++; $display("FAIL st_issue got en=%0h wr=%0h exp en=1 wr=1", bus.mem_en, bus.mem_wr);
        end
        checks++; if (bus.mem_w !== 32'h12345678) begin errors++; $display("FAIL st_mem_w got=%0h exp=12345678", bus.mem_w); end
        checks++; if (bus.mem_a !== 32'h208) begin errors++; $display("FAIL st_mem_a got=%0h exp=208", bus.mem_a); end
        step();
        step();
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_a !== 32'h208) begin
            errors++; $display("FAIL st_hold got en=%0h a=%0h exp en=1 a=208", bus.mem_en, bus.mem_a);
        end
        complete(32'h0);
        checks++; if (bus.mem_en !== 1'b0 || bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL st_done got en=%0h rv=%0h exp en=0 rv=0", bus.mem_en, bus.res_valid);
        end
        step();
    endtask

    task automatic test_cdb();
        bus.cdb_valid = 2'b10;
        bus.cdb_tag   = {4'd5, 4'd9};
        bus.cdb_val   = {32'h2000, 32'h0BAD};
        do_issue(4'd8, 1'b0, 3'b010, 1'b0, 32'h0, 4'd5, 32'h0, 32'h10);
        bus.cdb_valid = 2'b00;
        step();
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_a !== 32'h2010) begin
            errors++; $display("FAIL cdb_bypass got en=%0h a=%0h exp en=1 a=2010", bus.mem_en, bus.mem_a);
        end
        complete(32'h55);
        checks++; if (bus.res_valid !== 1'b1 || bus.res_rob !== 4'd8) begin
            errors++; $display("FAIL cdb_bypass_res got rv=%0h rob=%0h exp rv=1 rob=8", bus.res_valid, bus.res_rob);
        end
        step();
        do_issue(4'd9, 1'b0, 3'b010, 1'b0, 32'h0, 4'd6, 32'h0, 32'h4);
        bus.cdb_valid = 2'b11;
        bus.cdb_tag   = {4'd6, 4'd6};
        bus.cdb_val   = {32'h4000, 32'h3000};
        step();
        bus.cdb_valid = 2'b00;
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL cdb_capture_latency got=%0h exp=0", bus.mem_en); end
        step();
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_a !== 32'h3004) begin
            errors++; $display("FAIL cdb_lowest_channel got en=%0h a=%0h exp en=1 a=3004", bus.mem_en, bus.mem_a);
        end
        complete(32'h0);
        step();
    endtask

    task automatic test_io();
        bus.rob_head = 4'd6;
        do_issue(4'd7, 1'b0, 3'b010, 1'b1, 32'h30000, 4'd0, 32'h0, 32'h0);
        step();
        step();
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL io_stall got=%0h exp=0", bus.mem_en); end
        bus.rob_head = 4'd7;
        step();
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_a !== 32'h30000) begin
            errors++; $display("FAIL io_issue got en=%0h a=%0h exp en=1 a=30000", bus.mem_en, bus.mem_a);
        end
        complete(32'h77);
        checks++; if (bus.res_valid !== 1'b1 || bus.res_rob !== 4'd7 || bus.res !== 32'h77) begin
            errors++; $display("FAIL io_res got rv=%0h rob=%0h res=%0h exp rv=1 rob=7 res=77", bus.res_valid, bus.res_rob, bus.res);
        end
        bus.rob_head = 4'd0;
        step();
    endtask

    task automatic test_rdy_freeze();
        do_issue(4'd10, 1'b0, 3'b010, 1'b1, 32'h700, 4'd0, 32'h0, 32'h0);
        step();
        bus.rdy      = 1'b0;
        bus.mem_done = 1'b1;
        bus.mem_r    = 32'h99;
        step();
        step();
        checks++; if (bus.mem_en !== 1'b1 || bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL rdy_freeze got en=%0h rv=%0h exp en=1 rv=0", bus.mem_en, bus.res_valid);
        end
        bus.rdy = 1'b1;
        step();
        bus.mem_done = 1'b0;
        checks++; if (bus.mem_en !== 1'b0 || bus.res_valid !== 1'b1 || bus.res !== 32'h99) begin
            errors++; $display("FAIL rdy_resume got en=%0h rv=%0h res=%0h exp en=0 rv=1 res=99", bus.mem_en, bus.res_valid, bus.res);
        end
        step();
    endtask

    task automatic test_full_rollback();
        for (int i = 0; i < 16; i++) begin
            do_issue(4'(i + 1), (i < 2), 3'b010, 1'b0, 32'h0, 4'd14, 32'hAAAA0001 + 32'(i), 32'(i * 4));
            if (i == 14) begin
                checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL full_at_15 got=%0h exp=0", bus.full); end
            end
        end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_at_16 got=%0h exp=1", bus.full); end
        do_issue(4'd11, 1'b0, 3'b010, 1'b1, 32'h900, 4'd0, 32'h0, 32'h0);
        step();
        checks++; if (bus.mem_en !== 1'b0 || bus.full !== 1'b1) begin
            errors++; $display("FAIL enq_when_full got en=%0h full=%0h exp en=0 full=1", bus.mem_en, bus.full);
        end
        bus.commit_valid = 1'b1;
        bus.commit_rob   = 4'd1;
        step();
        bus.commit_rob   = 4'd2;
        step();
        bus.commit_valid = 1'b0;
        bus.rollback     = 1'b1;
        step();
        bus.rollback     = 1'b0;
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL rollback_full got=%0h exp=0", bus.full); end
        for (int i = 0; i < 14; i++) begin
            do_issue(4'(i + 3), 1'b0, 3'b010, 1'b0, 32'h0, 4'd13, 32'h0, 32'h0);
            if (i == 12) begin
                checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL refill_count_15 got=%0h exp=0", bus.full); end
            end
        end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL refill_count_16 got=%0h exp=1", bus.full); end
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {4'd0, 4'd14};
        bus.cdb_val   = {32'h0, 32'h400};
        step();
        bus.cdb_valid = 2'b00;
        step();
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h400 || bus.mem_w !== 32'hAAAA0001) begin
            errors++; $display("FAIL kept_store0 got en=%0h wr=%0h a=%0h w=%0h exp 1 1 400 aaaa0001", bus.mem_en, bus.mem_wr, bus.mem_a, bus.mem_w);
        end
        complete(32'h0);
        step();
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_a !== 32'h404 || bus.mem_w !== 32'hAAAA0002) begin
            errors++; $display("FAIL kept_store1 got en=%0h a=%0h w=%0h exp 1 404 aaaa0002", bus.mem_en, bus.mem_a, bus.mem_w);
        end
        complete(32'h0);
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL after_pops_full got=%0h exp=0", bus.full); end
        bus.rollback = 1'b1;
        step();
        bus.rollback = 1'b0;
    endtask

    task automatic test_squash();
        do_issue(4'd5, 1'b0, 3'b010, 1'b1, 32'h500, 4'd0, 32'h0, 32'h0);
        step();
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_a !== 32'h500) begin
            errors++; $display("FAIL squash_launch got en=%0h a=%0h exp en=1 a=500", bus.mem_en, bus.mem_a);
        end
        bus.rollback = 1'b1;
        step();
        bus.rollback = 1'b0;
        do_issue(4'd6, 1'b0, 3'b010, 1'b1, 32'h600, 4'd0, 32'h0, 32'h0);
        complete(32'h1234);
        checks++; if (bus.res_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
            errors++; $display("FAIL squash_suppress got rv=%0h en=%0h exp rv=0 en=0", bus.res_valid, bus.mem_en);
        end
        step();
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_a !== 32'h600) begin
            errors++; $display("FAIL post_squash_launch got en=%0h a=%0h exp en=1 a=600", bus.mem_en, bus.mem_a);
        end
        complete(32'h5678);
        checks++; if (bus.res_valid !== 1'b1 || bus.res !== 32'h5678 || bus.res_rob !== 4'd6) begin
            errors++; $display("FAIL post_squash_res got rv=%0h res=%0h rob=%0h exp 1 5678 6", bus.res_valid, bus.res, bus.res_rob);
        end
        step();
    endtask

    initial begin
        bus.rdy = 1'b1;            bus.rollback = 1'b0;
        bus.issue_en = 1'b0;       bus.issue_rob = '0;      bus.issue_ls = 1'b0;
        bus.issue_funct3 = '0;     bus.issue_rs1_rdy = 1'b0; bus.issue_rs2_rdy = 1'b0;
        bus.issue_rs1_val = '0;    bus.issue_rs2_val = '0;
        bus.issue_rs1_tag = '0;    bus.issue_rs2_tag = '0;  bus.issue_imm = '0;
        bus.cdb_valid = '0;        bus.cdb_tag = '0;        bus.cdb_val = '0;
        bus.commit_valid = 1'b0;   bus.commit_rob = '0;     bus.rob_head = '0;
        bus.mem_done = 1'b0;       bus.mem_r = '0;
        step();
        test_reset();
        test_lw();
        test_extension();
        test_store();
        test_cdb();
        test_io();
        test_rdy_freeze();
        test_full_rollback();
        test_squash();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
